// File: rtl/iir_frame_ctrl_if.sv
// Bundle of host, input-RAM, filter and output-RAM signals around the frame sequencer.
// master = sequencer side, slave = environment (host, RAMs, filter).
interface iir_frame_ctrl_if #(
  parameter int unsigned DW = 24,
  parameter int unsigned AW = 11
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic [DW-1:0] in_rd_data;
  logic          flt_start;
  logic [DW-1:0] flt_data_in;
  logic          flt_data_in_valid;
  logic          flt_stable;
  logic [DW-1:0] flt_data_out;
  logic          flt_data_out_valid;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [DW-1:0] out_wr_data;
  logic [AW:0]   out_count;

  modport master (
    input  start, abort, in_rd_data, flt_stable, flt_data_out, flt_data_out_valid,
    output busy, done, err_timeout, in_rd_en, in_rd_addr, flt_start, flt_data_in,
           flt_data_in_valid, out_wr_en, out_wr_addr, out_wr_data, out_count
  );

  modport slave (
    output start, abort, in_rd_data, flt_stable, flt_data_out, flt_data_out_valid,
    input  busy, done, err_timeout, in_rd_en, in_rd_addr, flt_start, flt_data_in,
           flt_data_in_valid, out_wr_en, out_wr_addr, out_wr_data, out_count
  );
endinterface

// File: rtl/iir_frame_ctrl.sv
// Frame sequencer for the Q2.22 IIR filter: streams one frame from the input RAM,
// waits for filter stability, captures the filtered frame into the output RAM.
module iir_frame_ctrl #(
  parameter int unsigned DW        = 24,
  parameter int unsigned AW        = 11,
  parameter int unsigned FRAME_LEN = 2048,
  parameter int unsigned TIMEOUT   = 4095
) (
  input logic              clk,
  input logic              rst_n,
  iir_frame_ctrl_if.master bus
);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KICK   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [AW-1:0]  RD_LAST  = AW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FRAME_LEN);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic           stable_seen;
  logic [WDW-1:0] wdog;

  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic           rd_en_q;
  logic [AW-1:0]  rd_addr_q;
  logic           flt_start_q;
  logic           din_valid_q;
  logic           wr_en_q;
  logic [AW-1:0]  wr_addr_q;
  logic [DW-1:0]  wr_data_q;
  logic [CW-1:0]  count_q;

  logic           abort_hit;
  logic           start_acc;
  logic           cap_en;
  logic           rd_last;
  logic           wd_hit;

  // Next-state and per-cycle decode; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    abort_hit = bus.abort && (state != S_IDLE);
    start_acc = bus.start && (state == S_IDLE);
    rd_last   = (rd_addr_q == RD_LAST);
    wd_hit    = (wdog == WD_LAST);
    cap_en    = 1'b0;

    if (((state == S_STREAM) || (state == S_DRAIN)) && bus.flt_data_out_valid &&
        stable_seen && (count_q < CNT_FULL) && !abort_hit) begin
      cap_en = 1'b1;
    end

    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_KICK;
      S_KICK:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.flt_stable)  state_nxt = S_STREAM;
        else if (wd_hit)     state_nxt = S_ERR;
      end
      S_STREAM: if (rd_last) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (count_q == CNT_FULL)   state_nxt = S_DONE;
        else if (!cap_en && wd_hit) state_nxt = S_ERR;
      end
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    if (abort_hit) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Status and strobe outputs are decoded from the state being entered so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flt_start_q <= 1'b0;
      rd_en_q     <= 1'b0;
      din_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= (state_nxt != S_IDLE);
      done_q      <= (state_nxt == S_DONE);
      flt_start_q <= (state_nxt == S_KICK);
      rd_en_q     <= (state_nxt == S_STREAM);
      din_valid_q <= rd_en_q && !abort_hit;
      if (start_acc)                err_q <= 1'b0;
      else if (state_nxt == S_ERR)  err_q <= 1'b1;
    end
  end

  // Read address, stability flag and idle watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q   <= '0;
      stable_seen <= 1'b0;
      wdog        <= '0;
    end else begin
      if (start_acc)
        rd_addr_q <= '0;
      else if ((state == S_STREAM) && !rd_last && !abort_hit)
        rd_addr_q <= rd_addr_q + AW'(1);

      if (start_acc)
        stable_seen <= 1'b0;
      else if ((state == S_WAIT) && bus.flt_stable && !abort_hit)
        stable_seen <= 1'b1;

      if (start_acc || (state_nxt != state))
        wdog <= '0;
      else if (state == S_WAIT)
        wdog <= wdog + WDW'(1);
      else if (state == S_DRAIN)
        wdog <= cap_en ? '0 : wdog + WDW'(1);
    end
  end

  // Output capture: the write lands one cycle after the accepted filter strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
    end else begin
      wr_en_q <= cap_en;
      if (start_acc) begin
        count_q <= '0;
      end else if (cap_en) begin
        wr_addr_q <= count_q[AW-1:0];
        wr_data_q <= bus.flt_data_out;
        count_q   <= count_q + CW'(1);
      end
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.err_timeout       = err_q;
  assign bus.in_rd_en          = rd_en_q;
  assign bus.in_rd_addr        = rd_addr_q;
  assign bus.flt_start         = flt_start_q;
  assign bus.flt_data_in       = bus.in_rd_data;
  assign bus.flt_data_in_valid = din_valid_q;
  assign bus.out_wr_en         = wr_en_q;
  assign bus.out_wr_addr       = wr_addr_q;
  assign bus.out_wr_data       = wr_data_q;
  assign bus.out_count         = count_q;
endmodule
